// File: rtl/addr_decode_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : addr_decode_seq_if
//  Description : Request/enable bundle between the bus address phase and the
//                registered channel decoder addr_decode_seq.
//  Revision    : 1.0 - initial release
// ============================================================================
interface addr_decode_seq_if #(
   parameter int AW = 8,
   parameter int SW = 3,
   parameter int CW = 8
);
   localparam int NCH = 2 ** SW;

   logic [AW-1:0]  a;
   logic           a_valid;
   logic           a_ready;
   logic           done;
   logic           adr_match;
   logic [NCH-1:0] en;
   logic           miss;
   logic [CW-1:0]  miss_cnt;
   logic           err;

   modport master (
      output a, a_valid, done,
      input  a_ready, adr_match, en, miss, miss_cnt, err
   );

   modport slave (
      input  a, a_valid, done,
      output a_ready, adr_match, en, miss, miss_cnt, err
   );
endinterface
`default_nettype wire

// File: rtl/addr_decode_seq.sv
`default_nettype none
// ============================================================================
//  Module      : addr_decode_seq
//  Description : Registered address decoder: accepts a request, drives a
//                held one-hot channel enable until DONE, counts misses.
//                Optional forced release via macro ADDR_DECODE_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module addr_decode_seq #(
   parameter int            AW      = 8,
   parameter int            SW      = 3,
   parameter logic [AW-SW-1:0] BASE = '1,
   parameter int            CW      = 8,
   parameter int            TIMEOUT = 16
) (
   input  wire               clk,
   input  wire               rst,
   addr_decode_seq_if.slave  bus
);
   localparam int NCH = 2 ** SW;
   localparam logic [CW-1:0] c_cnt_one = CW'(1);

   typedef enum logic [0:0] {
      S_IDLE   = 1'b0,
      S_ACTIVE = 1'b1
   } state_t;

   state_t         r_state;
   state_t         w_state_nxt;
   logic [NCH-1:0] r_en;
   logic [NCH-1:0] w_en_nxt;
   logic           r_adr_match;
   logic           w_match_nxt;
   logic           r_miss;
   logic           w_miss_nxt;
   logic [CW-1:0]  r_miss_cnt;
   logic [CW-1:0]  w_cnt_nxt;
   logic           r_err;
   logic           w_err_nxt;

   if (AW <= SW || TIMEOUT < 2) begin : g_param_check
      $error("addr_decode_seq: needs AW > SW and TIMEOUT >= 2");
   end

`ifdef ADDR_DECODE_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT);
   localparam logic [TW-1:0] c_tmo_last = TW'(TIMEOUT - 1);
   logic [TW-1:0] r_tmo_cnt;
   logic [TW-1:0] w_tmo_nxt;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_en        <= '0;
         r_adr_match <= 1'b0;
         r_miss      <= 1'b0;
         r_miss_cnt  <= '0;
         r_err       <= 1'b0;
`ifdef ADDR_DECODE_TIMEOUT_EN
         r_tmo_cnt   <= '0;
`endif
      end else begin
         r_state     <= w_state_nxt;
         r_en        <= w_en_nxt;
         r_adr_match <= w_match_nxt;
         r_miss      <= w_miss_nxt;
         r_miss_cnt  <= w_cnt_nxt;
         r_err       <= w_err_nxt;
`ifdef ADDR_DECODE_TIMEOUT_EN
         r_tmo_cnt   <= w_tmo_nxt;
`endif
      end
   end

   // a_valid alone qualifies accept here: a_ready is high exactly in IDLE out of reset
   always_comb begin
      w_state_nxt = r_state;
      w_en_nxt    = r_en;
      w_match_nxt = r_adr_match;
      w_miss_nxt  = 1'b0;
      w_cnt_nxt   = r_miss_cnt;
      w_err_nxt   = 1'b0;
`ifdef ADDR_DECODE_TIMEOUT_EN
      w_tmo_nxt   = r_tmo_cnt;
`endif
      case (r_state)
         S_IDLE: begin
            w_en_nxt    = '0;
            w_match_nxt = 1'b0;
`ifdef ADDR_DECODE_TIMEOUT_EN
            w_tmo_nxt   = '0;
`endif
            if (bus.a_valid) begin
               if (bus.a[AW-1:SW] == BASE) begin
                  w_state_nxt               = S_ACTIVE;
                  w_en_nxt[bus.a[SW-1:0]]   = 1'b1;
                  w_match_nxt               = 1'b1;
               end else begin
                  w_miss_nxt = 1'b1;
                  if (r_miss_cnt != '1) begin
                     w_cnt_nxt = r_miss_cnt + c_cnt_one;
                  end
               end
            end
         end
         S_ACTIVE: begin
            if (bus.done) begin
               w_state_nxt = S_IDLE;
               w_en_nxt    = '0;
               w_match_nxt = 1'b0;
            end
`ifdef ADDR_DECODE_TIMEOUT_EN
            // DONE on the expiry edge takes priority, so ERR stays low then
            else if (r_tmo_cnt == c_tmo_last) begin
               w_state_nxt = S_IDLE;
               w_en_nxt    = '0;
               w_match_nxt = 1'b0;
               w_err_nxt   = 1'b1;
            end else begin
               w_tmo_nxt = r_tmo_cnt + TW'(1);
            end
`endif
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_en_nxt    = '0;
            w_match_nxt = 1'b0;
         end
      endcase
   end

   assign bus.a_ready   = (r_state == S_IDLE) && !rst;
   assign bus.en        = r_en;
   assign bus.adr_match = r_adr_match;
   assign bus.miss      = r_miss;
   assign bus.miss_cnt  = r_miss_cnt;
   assign bus.err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_addr_decode_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_addr_decode_seq
//  Description : Self-checking bench for addr_decode_seq against a
//                transaction-level model, plus pinned literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_addr_decode_seq;
   localparam int AW      = 8;
   localparam int SW      = 3;
   localparam int CW      = 8;
   localparam int NCH     = 2 ** SW;
   localparam int TIMEOUT = 16;
   localparam int BASE_V  = 31;
   localparam int MAXC    = 255;
`ifdef ADDR_DECODE_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;

   addr_decode_seq_if #(.AW(AW), .SW(SW), .CW(CW)) bus ();

   addr_decode_seq #(
      .AW(AW), .SW(SW), .BASE('1), .CW(CW), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   always #5 clk = ~clk;

   // Transaction-level model: busy flag, target channel, saturating miss count
   bit m_busy = 1'b0;
   int m_ch   = 0;
   bit m_miss = 1'b0;
   int m_cnt  = 0;
   bit m_err  = 1'b0;
   int m_age  = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy <= 1'b0; m_ch <= 0; m_miss <= 1'b0;
         m_cnt  <= 0;    m_err <= 1'b0; m_age <= 0;
      end else begin
         m_miss <= 1'b0;
         m_err  <= 1'b0;
         if (!m_busy) begin
            if (bus.a_valid) begin
               if ((int'(bus.a) / NCH) == BASE_V) begin
                  m_busy <= 1'b1;
                  m_ch   <= int'(bus.a) % NCH;
                  m_age  <= 0;
               end else begin
                  m_miss <= 1'b1;
                  m_cnt  <= (m_cnt < MAXC) ? m_cnt + 1 : m_cnt;
               end
            end
         end else begin
            m_age <= m_age + 1;
            if (bus.done) begin
               m_busy <= 1'b0;
            end else if (TMO_EN && (m_age + 1 >= TIMEOUT)) begin
               m_busy <= 1'b0;
               m_err  <= 1'b1;
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      logic [NCH-1:0] exp_en;
      exp_en = m_busy ? (NCH'(1) << m_ch) : '0;
      chk("model_en",        32'(bus.en),        32'(exp_en));
      chk("model_adr_match", 32'(bus.adr_match), 32'(m_busy));
      chk("model_a_ready",   32'(bus.a_ready),   32'(!m_busy && !rst));
      chk("model_miss",      32'(bus.miss),      32'(m_miss));
      chk("model_miss_cnt",  32'(bus.miss_cnt),  32'(m_cnt));
      chk("model_err",       32'(bus.err),       32'(m_err));
   end

   task automatic req(input logic [AW-1:0] addr);
      @(negedge clk);
      bus.a       = addr;
      bus.a_valid = 1'b1;
      @(negedge clk);
      bus.a_valid = 1'b0;
   endtask

   task automatic done_after(input int d);
      repeat (d) @(negedge clk);
      bus.done = 1'b1;
      @(negedge clk);
      bus.done = 1'b0;
   endtask

   logic [AW-1:0] vec_a [7] = '{8'hF8, 8'hFF, 8'h00, 8'hFC, 8'hA5, 8'hF9, 8'hFE};
   int            vec_d [7] = '{0, 2, 0, 1, 0, 3, 0};

   initial begin
      bus.a = '0; bus.a_valid = 1'b0; bus.done = 1'b0;
      #8;
      chk("rst_a_ready",  32'(bus.a_ready),  32'd0);
      chk("rst_miss_cnt", 32'(bus.miss_cnt), 32'd0);
      #4 rst = 1'b0;
      #1;
      chk("post_rst_a_ready", 32'(bus.a_ready), 32'd1);
      chk("post_rst_en",      32'(bus.en),      32'd0);

      // Match at 0xFD -> channel 5
      req(8'hFD);
      chk("fd_en",      32'(bus.en),        32'h20);
      chk("fd_match",   32'(bus.adr_match), 32'd1);
      chk("fd_a_ready", 32'(bus.a_ready),   32'd0);
      done_after(2);
      chk("fd_rel_en",      32'(bus.en),      32'd0);
      chk("fd_rel_a_ready", 32'(bus.a_ready), 32'd1);

      // Miss at 0x7D
      req(8'h7D);
      chk("miss_pulse", 32'(bus.miss),     32'd1);
      chk("miss_en",    32'(bus.en),       32'd0);
      chk("miss_cnt1",  32'(bus.miss_cnt), 32'd1);
      @(negedge clk);
      chk("miss_width", 32'(bus.miss),     32'd0);

      // Requests while busy are ignored
      req(8'hFB);
      chk("busy_en", 32'(bus.en), 32'h08);
      bus.a = 8'hF8; bus.a_valid = 1'b1;
      repeat (4) begin
         @(negedge clk);
         chk("busy_hold_en", 32'(bus.en),   32'h08);
         chk("busy_no_miss", 32'(bus.miss), 32'd0);
      end
      bus.a_valid = 1'b0;
      done_after(0);

      foreach (vec_a[i]) begin
         req(vec_a[i]);
         if ((vec_a[i] >> SW) == 5'h1F) done_after(vec_d[i]);
      end

      // 300 back-to-back misses saturate the counter
      @(negedge clk);
      bus.a = 8'h00; bus.a_valid = 1'b1;
      repeat (300) @(negedge clk);
      bus.a_valid = 1'b0;
      chk("miss_sat", 32'(bus.miss_cnt), 32'd255);

      // Asynchronous reset mid-ACTIVE
      req(8'hFF);
      chk("ff_en", 32'(bus.en), 32'h80);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_en",    32'(bus.en),        32'd0);
      chk("async_rst_match", 32'(bus.adr_match), 32'd0);
      chk("async_rst_cnt",   32'(bus.miss_cnt),  32'd0);
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("rel_a_ready", 32'(bus.a_ready), 32'd1);

`ifdef ADDR_DECODE_TIMEOUT_EN
      req(8'hF2 | 8'hF8);
      repeat (15) @(negedge clk);
      chk("tmo_before_en", 32'(bus.en) != 0 ? 32'd1 : 32'd0, 32'd1);
      @(negedge clk);
      chk("tmo_en",  32'(bus.en),  32'd0);
      chk("tmo_err", 32'(bus.err), 32'd1);
      @(negedge clk);
      chk("tmo_err_width", 32'(bus.err), 32'd0);
      req(8'hF9);
      repeat (15) @(negedge clk);
      bus.done = 1'b1;
      @(negedge clk);
      bus.done = 1'b0;
      chk("tmo_done_en",  32'(bus.en),  32'd0);
      chk("tmo_done_err", 32'(bus.err), 32'd0);
`else
      // Without the timeout, ACTIVE is held well beyond TIMEOUT cycles
      req(8'hFA);
      repeat (40) @(negedge clk);
      chk("hold_en",  32'(bus.en),  32'h04);
      chk("hold_err", 32'(bus.err), 32'd0);
      done_after(0);
`endif
      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
`default_nettype wire
